// File: rtl/demux_frame_sequencer.sv
// Purpose : serializes destination-tagged parallel words MSB-first for a 4-way serial demux.
// Latency : first data bit appears on o_ser_out one cycle after the accept edge.
// Backpress: o_in_ready is high only in IDLE; the word is taken on i_in_valid && o_in_ready.
//
// Optional feature: define FRAME_PARITY_EN to append an even-parity bit to every frame.
//
// Ports:
//   i_clk          rising-edge clock
//   i_rst_n        synchronous active-low reset
//   i_in_valid     upstream word valid
//   o_in_ready     block can accept a word this cycle
//   i_in_data      payload word (DATA_W bits)
//   i_in_dest      destination channel 0..3
//   o_sel          select to downstream demux, stable for the whole frame and its guard gap
//   o_ser_out      serial bit to the downstream demux data input
//   o_busy         frame in progress (SHIFT, PARITY or GAP)
//   o_frame_done   one-cycle pulse coincident with the last bit of a frame
//   o_frame_cnt    completed-frame count, 8-bit wrapping
module demux_frame_sequencer #(
    parameter int   DATA_W     = 8,
    parameter int   GAP_CYCLES = 1,
    parameter logic INACTIVE   = 1'b0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [DATA_W-1:0] i_in_data,
    input  logic [1:0]        i_in_dest,
    output logic [1:0]        o_sel,
    output logic              o_ser_out,
    output logic              o_busy,
    output logic              o_frame_done,
    output logic [7:0]        o_frame_cnt
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DATA_W - 1);
    localparam logic [3:0] GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SHIFT  = 2'd1;
`ifdef FRAME_PARITY_EN
    localparam logic [1:0] S_PARITY = 2'd2;
`endif
    localparam logic [1:0] S_GAP    = 2'd3;

    logic [1:0]        r_state;
    logic [DATA_W-1:0] r_shift;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic [3:0]        r_gap_cnt;
    logic [1:0]        r_sel;
    logic              r_ser;
    logic              r_ready;
    logic              r_busy;
    logic              r_done;
    logic [7:0]        r_frame_cnt;
`ifdef FRAME_PARITY_EN
    logic              r_parity;
`endif

    wire w_accept   = i_in_valid && r_ready;
    wire w_last_bit = (r_bit_cnt == '0);

    // Outputs are registered and always reflect the current state, so every
    // value below is prepared one edge ahead of the cycle it describes.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_gap_cnt   <= '0;
            r_sel       <= 2'b00;
            r_ser       <= INACTIVE;
            r_ready     <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_frame_cnt <= 8'd0;
`ifdef FRAME_PARITY_EN
            r_parity    <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state   <= S_SHIFT;
                        r_sel     <= i_in_dest;
                        // MSB goes straight to the output register; the rest
                        // waits in the shift register.
                        r_ser     <= i_in_data[DATA_W-1];
                        r_shift   <= {i_in_data[DATA_W-2:0], 1'b0};
                        r_bit_cnt <= CNT_LOAD;
                        r_ready   <= 1'b0;
                        r_busy    <= 1'b1;
`ifdef FRAME_PARITY_EN
                        r_parity  <= ^i_in_data;
`endif
                    end
                end

                S_SHIFT: begin
                    if (!w_last_bit) begin
                        r_ser     <= r_shift[DATA_W-1];
                        r_shift   <= {r_shift[DATA_W-2:0], 1'b0};
                        r_bit_cnt <= r_bit_cnt - 1'b1;
`ifndef FRAME_PARITY_EN
                        // Next cycle shows the last data bit: pulse done with it.
                        if (r_bit_cnt == CNT_W'(1)) begin
                            r_done      <= 1'b1;
                            r_frame_cnt <= r_frame_cnt + 8'd1;
                        end
`endif
                    end else begin
`ifdef FRAME_PARITY_EN
                        r_state     <= S_PARITY;
                        r_ser       <= r_parity;
                        r_done      <= 1'b1;
                        r_frame_cnt <= r_frame_cnt + 8'd1;
`else
                        r_ser <= INACTIVE;
                        if (GAP_CYCLES > 0) begin
                            r_state   <= S_GAP;
                            r_gap_cnt <= GAP_LOAD;
                        end else begin
                            r_state <= S_IDLE;
                            r_ready <= 1'b1;
                            r_busy  <= 1'b0;
                        end
`endif
                    end
                end

`ifdef FRAME_PARITY_EN
                S_PARITY: begin
                    r_ser <= INACTIVE;
                    if (GAP_CYCLES > 0) begin
                        r_state   <= S_GAP;
                        r_gap_cnt <= GAP_LOAD;
                    end else begin
                        r_state <= S_IDLE;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
`endif

                S_GAP: begin
                    r_ser <= INACTIVE;
                    if (r_gap_cnt == 4'd0) begin
                        r_state <= S_IDLE;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 4'd1;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_ser   <= INACTIVE;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_in_ready   = r_ready;
    assign o_sel        = r_sel;
    assign o_ser_out    = r_ser;
    assign o_busy       = r_busy;
    assign o_frame_done = r_done;
    assign o_frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_demux_frame_sequencer.sv
// Purpose : directed self-checking bench for demux_frame_sequencer.
// Latency : checks first bit one cycle after accept, done on the last frame bit.
// Backpress: holds in_valid across busy periods to confirm words are only taken when ready.
module tb_demux_frame_sequencer;

    localparam int DW = 8;
`ifdef FRAME_PARITY_EN
    localparam int FB  = DW + 1;
    localparam bit PAR = 1'b1;
`else
    localparam int FB  = DW;
    localparam bit PAR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;

    // instance with one guard cycle
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [1:0] in_dest;
    logic [1:0] sel;
    logic       ser;
    logic       busy;
    logic       done;
    logic [7:0] fcnt;

    // instance with no guard cycles
    logic       v0;
    logic       rdy0;
    logic [7:0] d0;
    logic [1:0] dest0;
    logic [1:0] sel0;
    logic       ser0;
    logic       busy0;
    logic       done0;
    logic [7:0] fcnt0;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_cnt  = 0;

    always #5 clk = ~clk;

    demux_frame_sequencer #(.DATA_W(DW), .GAP_CYCLES(1), .INACTIVE(1'b0)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(in_ready),
        .i_in_data(in_data), .i_in_dest(in_dest), .o_sel(sel), .o_ser_out(ser),
        .o_busy(busy), .o_frame_done(done), .o_frame_cnt(fcnt)
    );

    demux_frame_sequencer #(.DATA_W(DW), .GAP_CYCLES(0), .INACTIVE(1'b0)) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(v0), .o_in_ready(rdy0),
        .i_in_data(d0), .i_in_dest(dest0), .o_sel(sel0), .o_ser_out(ser0),
        .o_busy(busy0), .o_frame_done(done0), .o_frame_cnt(fcnt0)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered on the first-bit cycle; leaves on the last-bit cycle of the frame.
    task automatic chk_bits(input logic [7:0] d, input logic [1:0] dst);
        for (int i = DW - 1; i >= 0; i--) begin
            check("sel_frame", sel, dst);
            check("ser_bit", ser, d[i]);
            check("busy_frame", busy, 1);
            check("ready_frame", in_ready, 0);
            check("done_bit", done, (i == 0 && !PAR));
            if (i > 0) tick();
        end
        if (PAR) begin
            tick();
            check("parity_bit", ser, ^d);
            check("done_parity", done, 1);
        end
        exp_cnt = (exp_cnt + 1) % 256;
        check("cnt_at_done", fcnt, exp_cnt);
    endtask

    task automatic gap_then_idle(input logic [1:0] dst);
        tick();
        check("gap_ser", ser, 0);
        check("gap_busy", busy, 1);
        check("gap_ready", in_ready, 0);
        check("gap_done", done, 0);
        check("gap_sel", sel, dst);
        tick();
        check("idle_ready", in_ready, 1);
        check("idle_busy", busy, 0);
        check("idle_ser", ser, 0);
        check("idle_sel", sel, dst);
        check("idle_cnt", fcnt, exp_cnt);
    endtask

    task automatic run_frame(input logic [7:0] d, input logic [1:0] dst);
        in_valid = 1'b1;
        in_data  = d;
        in_dest  = dst;
        tick();
        in_valid = 1'b0;
        chk_bits(d, dst);
        gap_then_idle(dst);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset held with a valid word presented: nothing may be accepted.
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'hAA;
        in_dest  = 2'd3;
        v0       = 1'b0;
        d0       = 8'h00;
        dest0    = 2'd0;
        repeat (3) tick();
        check("rst_ready", in_ready, 1);
        check("rst_sel", sel, 0);
        check("rst_ser", ser, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_cnt", fcnt, 0);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        tick();
        check("post_rst_busy", busy, 0);
        check("post_rst_sel", sel, 0);

        // Single frame A5 -> dest 2: bits 1,0,1,0,0,1,0,1
        run_frame(8'hA5, 2'd2);

        // Back-to-back with in_valid held high; data changes while not ready.
        in_valid = 1'b1;
        in_data  = 8'h01;
        in_dest  = 2'd3;
        tick();
        in_data  = 8'hFF;
        in_dest  = 2'd1;
        chk_bits(8'h01, 2'd3);
        tick();
        check("b2b_gap_sel", sel, 3);
        check("b2b_gap_ser", ser, 0);
        check("b2b_gap_ready", in_ready, 0);
        tick();
        check("b2b_idle_ready", in_ready, 1);
        check("b2b_idle_sel", sel, 3);
        tick();
        in_valid = 1'b0;
        chk_bits(8'hFF, 2'd1);
        gap_then_idle(2'd1);
        check("cnt_after_three", fcnt, 3);

        // Reset in the middle of F0.
        in_valid = 1'b1;
        in_data  = 8'hF0;
        in_dest  = 2'd2;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        check("mid_bit4", ser, 1);
        check("mid_busy", busy, 1);
        rst_n = 1'b0;
        tick();
        check("abort_busy", busy, 0);
        check("abort_ready", in_ready, 1);
        check("abort_ser", ser, 0);
        check("abort_done", done, 0);
        check("abort_cnt", fcnt, 0);
        check("abort_sel", sel, 0);
        rst_n   = 1'b1;
        exp_cnt = 0;
        tick();
        check("after_abort_done", done, 0);
        check("after_abort_busy", busy, 0);

`ifdef FRAME_PARITY_EN
        // 07 has three ones -> parity 1; 03 has two -> parity 0.
        run_frame(8'h07, 2'd0);
        run_frame(8'h03, 2'd1);
`endif

        // 256 frames with no guard gap: frame bits then a single IDLE bubble.
        for (int f = 0; f < 256; f++) begin
            logic [7:0] fb;
            logic [7:0] ec;
            fb    = 8'(f);
            ec    = 8'(f + 1);
            v0    = 1'b1;
            d0    = fb;
            dest0 = fb[1:0];
            tick();
            v0 = 1'b0;
            check("wrap_first_bit", ser0, fb[7]);
            check("wrap_sel", sel0, fb[1:0]);
            repeat (FB - 1) tick();
            check("wrap_done", done0, 1);
            check("wrap_cnt", fcnt0, ec);
            tick();
            check("wrap_bubble_ready", rdy0, 1);
            check("wrap_bubble_done", done0, 0);
        end
        check("wrap_final_cnt", fcnt0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/demux_frame_sequencer.md
Name: demux_frame_sequencer

Overview:
- Upstream feeder for the 4-way serial demultiplexer; drives its 2-bit select and 1-bit data input.
- Accepts parallel words tagged with a 2-bit destination over a valid/ready handshake.
- Serializes each word MSB-first onto one line, holding the select steady for the whole frame.
- Inserts inactive guard cycles between frames so the downstream demux never sees a select change mid-frame.

Parameters:
- DATA_W, 8, payload bits per frame (legal range 2..32)
- GAP_CYCLES, 1, inactive guard cycles after each frame (0..15; 0 = back-to-back capable)
- INACTIVE, 0, level driven on ser_out when no data bit is being sent

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  upstream word valid
- in_ready  output  1  block can accept a word this cycle
- in_data  input  DATA_W  payload word
- in_dest  input  2  destination channel 0..3
- sel  output  2  select to downstream demux
- ser_out  output  1  serial bit to downstream demux data input
- busy  output  1  frame in progress (SHIFT, PARITY or GAP)
- frame_done  output  1  one-cycle pulse on the cycle the last frame bit is driven
- frame_cnt  output  8  count of completed frames, wraps 255->0

Behaviour:
- Synchronous active-low reset, sampled on rising clk. During and after reset: state=IDLE, in_ready=1, sel=2'b00, ser_out=INACTIVE, busy=0, frame_done=0, frame_cnt=0, shift register and bit counter cleared.
- A reset asserted mid-frame aborts the frame. No frame_done pulse is generated, and frame_cnt is cleared.
- All outputs are registered.
- FSM states: IDLE, SHIFT, PARITY (only with the feature enabled), GAP.
- IDLE:
  - in_ready=1; ser_out=INACTIVE; sel holds its last value.
  - Accept occurs on a clk edge with in_valid && in_ready: latch in_data into the shift register and in_dest into sel, load bit counter = DATA_W-1, go to SHIFT.
  - in_data and in_dest are ignored when in_valid=0.
- SHIFT:
  - Entered the cycle after the accept, so latency from accept to first data bit on ser_out is 1 cycle.
  - ser_out = current MSB; shift left each cycle; decrement the counter; busy=1; in_ready=0.
  - The frame lasts exactly DATA_W cycles.
  - On the cycle the counter reads 0: if the feature is off, assert frame_done and increment frame_cnt, then go to GAP, or to IDLE if GAP_CYCLES=0. If the feature is on, go to PARITY without asserting frame_done.
- PARITY (feature only):
  - One cycle; ser_out = even parity of the latched word.
  - Assert frame_done and increment frame_cnt in this cycle.
  - Next state is GAP, or IDLE if GAP_CYCLES=0.
- GAP:
  - Lasts GAP_CYCLES cycles; ser_out=INACTIVE; sel holds the destination; busy=1; in_ready=0.
  - Go to IDLE after the last gap cycle.
- sel changes only on an accept edge; it never changes while busy=1.
- With GAP_CYCLES=0, the earliest next accept is the first IDLE cycle, so there is a minimum 1-cycle IDLE bubble between frames.
- in_valid held high with changing data while in_ready=0 has no effect.
- frame_cnt is 8-bit modulo: 255+1 -> 0, with no sticky overflow.
- frame_done is never asserted in IDLE or GAP.

Optional Feature:
- Macro FRAME_PARITY_EN.
- Defined: PARITY state present; each frame is DATA_W+1 bits, ending in an even-parity bit; frame_done is asserted on the parity bit.
- Undefined: the PARITY state and parity logic are absent; each frame is DATA_W bits; frame_done is asserted on the last data bit.
- Ports are identical in both builds.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles while in_valid=1 -> in_ready=1, sel=0, ser_out=0, busy=0, frame_cnt=0, no accept.
- Single frame: in_data=8'hA5, in_dest=2 -> sel=2 from the next cycle; ser_out=1,0,1,0,0,1,0,1 over 8 cycles; frame_done on the 8th bit; 1 GAP cycle with ser_out=0; then IDLE with frame_cnt=1.
- Back-to-back: in_valid held high with words 8'h01 to dest 3 and 8'hFF to dest 1 -> second accept only once in_ready returns; sel stays 3 for all of frame 1 and its gap, then becomes 1; no bit lost or duplicated.
- Reset mid-frame: rst_n=0 at bit 4 of 8'hF0 -> next cycle in IDLE, ser_out=INACTIVE, frame_cnt=0, no frame_done.
- Counter wrap: 256 frames with GAP_CYCLES=0 -> frame_cnt reads 255 then 0; each frame occupies 8 cycles plus a 1-cycle IDLE bubble.
- FRAME_PARITY_EN build: 8'h07 -> 8 data bits then parity bit 1; frame_done on the 9th bit; 8'h03 -> parity bit 0.
